// File: rtl/snake_sound.sv
// Sound sequencer for the snake game: short beep per food pulse, two-note
// descending melody once per game-over, with a registered "sound active" flag.
module snake_sound #(
  parameter int EAT_HALF = 50000,
  parameter int EAT_LEN  = 10000000,
  parameter int GO_HALF1 = 75758,
  parameter int GO_HALF2 = 113636,
  parameter int GO_LEN   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_eat,
  input  logic       i_gameOver,
  output logic       o_speaker,
  output logic       o_sound_on,
  output logic [2:0] o_state
);

  localparam int MAX_LEN  = (EAT_LEN > GO_LEN) ? EAT_LEN : GO_LEN;
  localparam int MAX_HALF = (EAT_HALF > GO_HALF1) ?
                            ((EAT_HALF > GO_HALF2) ? EAT_HALF : GO_HALF2) :
                            ((GO_HALF1 > GO_HALF2) ? GO_HALF1 : GO_HALF2);
  localparam int DW = $clog2(MAX_LEN) + 1;
  localparam int HW = $clog2(MAX_HALF) + 1;

  localparam logic [DW-1:0] EAT_END = DW'(EAT_LEN - 1);
  localparam logic [DW-1:0] GO_END  = DW'(GO_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EAT  = 3'd1,
    S_GO1  = 3'd2,
    S_GO2  = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_gop;
  logic [DW-1:0] r_dur;
  logic [HW-1:0] r_half;
  logic          r_speaker;
  logic          r_sound_on;

  state_t        w_next;
  logic          w_entry;
  logic          w_next_tone;
  logic          w_go_rise;
  logic [HW-1:0] w_half_end;

  assign w_go_rise = i_gameOver & ~r_gop;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    w_next  = r_state;
    w_entry = 1'b0;
    if (w_go_rise) begin
      w_next  = S_GO1;
      w_entry = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: if (i_eat && !i_gameOver) begin
          w_next  = S_EAT;
          w_entry = 1'b1;
        end
        S_EAT: begin
          // A fresh food pulse restarts the beep rather than queueing another.
          if (i_eat && !i_gameOver) begin
            w_next  = S_EAT;
            w_entry = 1'b1;
          end else if (r_dur == EAT_END) begin
            w_next = S_IDLE;
          end
        end
        S_GO1: if (r_dur == GO_END) begin
          w_next  = S_GO2;
          w_entry = 1'b1;
        end
        S_GO2: if (r_dur == GO_END) begin
          w_next = i_gameOver ? S_HOLD : S_IDLE;
        end
        S_HOLD: if (!i_gameOver) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_next_tone = (w_next == S_EAT) || (w_next == S_GO1) || (w_next == S_GO2);
    w_half_end  = '0;
    unique case (r_state)
      S_EAT:   w_half_end = HW'(EAT_HALF - 1);
      S_GO1:   w_half_end = HW'(GO_HALF1 - 1);
      S_GO2:   w_half_end = HW'(GO_HALF2 - 1);
      default: w_half_end = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gop      <= 1'b0;
      r_dur      <= '0;
      r_half     <= '0;
      r_speaker  <= 1'b0;
      r_sound_on <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_gop      <= i_gameOver;
      r_sound_on <= w_next_tone;
      if (w_entry) begin
        r_dur     <= '0;
        r_half    <= '0;
        r_speaker <= 1'b1;
      end else if (w_next_tone) begin
        r_dur <= r_dur + 1'b1;
        if (r_half == w_half_end) begin
          r_half    <= '0;
          r_speaker <= ~r_speaker;
        end else begin
          r_half <= r_half + 1'b1;
        end
      end else begin
        // Leaving a tone mid-half-period must silence the buzzer.
        r_dur     <= '0;
        r_half    <= '0;
        r_speaker <= 1'b0;
      end
    end
  end

  assign o_speaker  = r_speaker;
  assign o_sound_on = r_sound_on;
  assign o_state    = r_state;

endmodule

// File: tb/tb_snake_sound.sv
// Self-checking bench for snake_sound: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the sound rules.
module tb_snake_sound;

  localparam int EAT_HALF = 4;
  localparam int EAT_LEN  = 32;
  localparam int GO_HALF1 = 3;
  localparam int GO_HALF2 = 6;
  localparam int GO_LEN   = 24;

  logic       clk;
  logic       rst;
  logic       i_eat;
  logic       i_gameOver;
  logic       o_speaker;
  logic       o_sound_on;
  logic [2:0] o_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which tone (or silence) is active and how long it has been playing.
  int m_mode;     // 0 idle, 1 eat, 2 go note 1, 3 go note 2, 4 hold
  int m_elapsed;
  bit m_prev_go;

  snake_sound #(
    .EAT_HALF(EAT_HALF), .EAT_LEN(EAT_LEN), .GO_HALF1(GO_HALF1),
    .GO_HALF2(GO_HALF2), .GO_LEN(GO_LEN)
  ) dut (
    .clk(clk), .rst(rst), .i_eat(i_eat), .i_gameOver(i_gameOver),
    .o_speaker(o_speaker), .o_sound_on(o_sound_on), .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_elapsed = 0; m_prev_go = 1'b0;
  endtask

  task automatic model_step();
    bit eat_ok;
    eat_ok = i_eat && !i_gameOver;
    if (i_gameOver && !m_prev_go) begin
      m_mode = 2; m_elapsed = 0;
    end else begin
      case (m_mode)
        0: if (eat_ok) begin m_mode = 1; m_elapsed = 0; end
        1: if (eat_ok) m_elapsed = 0;
           else if (m_elapsed == EAT_LEN - 1) m_mode = 0;
           else m_elapsed++;
        2: if (m_elapsed == GO_LEN - 1) begin m_mode = 3; m_elapsed = 0; end
           else m_elapsed++;
        3: if (m_elapsed == GO_LEN - 1) m_mode = i_gameOver ? 4 : 0;
           else m_elapsed++;
        default: if (!i_gameOver) m_mode = 0;
      endcase
    end
    m_prev_go = i_gameOver;
  endtask

  // Expected {state, sound_on, speaker}: high for H cycles, low for H, repeating.
  function automatic logic [4:0] model_out();
    int h;
    logic spk;
    h = (m_mode == 1) ? EAT_HALF : (m_mode == 2) ? GO_HALF1 : GO_HALF2;
    spk = (m_mode >= 1 && m_mode <= 3) ? (((m_elapsed / h) % 2) == 0) : 1'b0;
    return {3'(m_mode), (m_mode >= 1 && m_mode <= 3), spk};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_eat = 1'b0; i_gameOver = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if ({o_state, o_sound_on, o_speaker} !== 5'b0) begin
      n_fail++; $display("FAIL reset_hold: got %b want 00000", {o_state, o_sound_on, o_speaker});
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if ({o_state, o_sound_on, o_speaker} !== 5'b0) begin
        n_fail++; $display("FAIL idle[%0d]: got %b want 00000", i, {o_state, o_sound_on, o_speaker});
      end
    end
    i_eat = 1'b1; tick(); i_eat = 1'b0;
    tick(); tick();
    n_checks++;
    if (o_sound_on !== 1'b1 || o_state !== 3'd1) begin
      n_fail++; $display("FAIL pre_async_eat: got state=%0d on=%b want state=1 on=1", o_state, o_sound_on);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({o_state, o_sound_on, o_speaker} !== 5'b0) begin
      n_fail++; $display("FAIL async_reset: got %b want 00000", {o_state, o_sound_on, o_speaker});
    end
    model_reset();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_eat();
    int on_cnt;
    logic want_spk;
    on_cnt = 0;
    i_eat = 1'b1; tick(); i_eat = 1'b0;
    for (int k = 0; k < 40; k++) begin
      want_spk = (k < 32) ? ((k % 8) < 4) : 1'b0;
      n_checks++;
      if (o_speaker !== want_spk || {o_state, o_sound_on, o_speaker} !== model_out()) begin
        n_fail++;
        $display("FAIL single_eat[%0d]: got %b want %b (spk want %b)", k,
                 {o_state, o_sound_on, o_speaker}, model_out(), want_spk);
      end
      if (o_sound_on) on_cnt++;
      tick();
    end
    n_checks++;
    if (on_cnt != 32) begin
      n_fail++; $display("FAIL single_eat_len: got %0d want 32", on_cnt);
    end
  endtask

  task automatic test_retrigger();
    int on_cnt;
    on_cnt = 0;
    i_eat = 1'b1; tick(); i_eat = 1'b0;
    for (int k = 0; k < 60; k++) begin
      n_checks++;
      if ({o_state, o_sound_on, o_speaker} !== model_out()) begin
        n_fail++; $display("FAIL retrigger[%0d]: got %b want %b", k, {o_state, o_sound_on, o_speaker}, model_out());
      end
      if (o_sound_on) on_cnt++;
      if (k == 9) begin
        i_eat = 1'b1; tick(); i_eat = 1'b0;
        n_checks++;
        if (o_speaker !== 1'b1) begin
          n_fail++; $display("FAIL retrigger_spk: got %b want 1", o_speaker);
        end
      end else begin
        tick();
      end
    end
    n_checks++;
    if (on_cnt != 42) begin
      n_fail++; $display("FAIL retrigger_len: got %0d want 42", on_cnt);
    end
  endtask

  task automatic test_go_preempt();
    int c_go1, c_go2;
    c_go1 = 0; c_go2 = 0;
    i_eat = 1'b1; tick(); i_eat = 1'b0;
    repeat (4) tick();
    i_gameOver = 1'b1; tick();
    for (int k = 0; k < 60; k++) begin
      n_checks++;
      if ({o_state, o_sound_on, o_speaker} !== model_out()) begin
        n_fail++; $display("FAIL go_preempt[%0d]: got %b want %b", k, {o_state, o_sound_on, o_speaker}, model_out());
      end
      if (o_state == 3'd2) c_go1++;
      if (o_state == 3'd3) c_go2++;
      tick();
    end
    n_checks++;
    if (c_go1 != 24 || c_go2 != 24 || o_state !== 3'd4 || o_sound_on !== 1'b0) begin
      n_fail++;
      $display("FAIL go_preempt_shape: got go1=%0d go2=%0d state=%0d on=%b want 24 24 4 0",
               c_go1, c_go2, o_state, o_sound_on);
    end
    for (int p = 0; p < 3; p++) begin
      i_eat = 1'b1; tick(); i_eat = 1'b0; tick();
      n_checks++;
      if (o_state !== 3'd4 || o_sound_on !== 1'b0 || o_speaker !== 1'b0) begin
        n_fail++; $display("FAIL hold_eat[%0d]: got state=%0d on=%b spk=%b want 4 0 0", p, o_state, o_sound_on, o_speaker);
      end
    end
    i_gameOver = 1'b0; tick();
    n_checks++;
    if (o_state !== 3'd0) begin
      n_fail++; $display("FAIL hold_exit: got %0d want 0", o_state);
    end
  endtask

  task automatic test_go_pulse();
    int on_cnt;
    on_cnt = 0;
    i_gameOver = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (k == 2) i_gameOver = 1'b0;
      n_checks++;
      if ({o_state, o_sound_on, o_speaker} !== model_out()) begin
        n_fail++; $display("FAIL go_pulse[%0d]: got %b want %b", k, {o_state, o_sound_on, o_speaker}, model_out());
      end
      if (o_sound_on) on_cnt++;
    end
    n_checks++;
    if (on_cnt != 48 || o_state !== 3'd0) begin
      n_fail++; $display("FAIL go_pulse_len: got on=%0d state=%0d want 48 0", on_cnt, o_state);
    end
  endtask

  task automatic test_go_at_reset();
    rst = 1'b1; model_reset();
    #1 i_gameOver = 1'b1;
    #1 rst = 1'b0;
    tick();
    n_checks++;
    if (o_state !== 3'd2 || o_sound_on !== 1'b1 || o_speaker !== 1'b1) begin
      n_fail++; $display("FAIL go_at_reset_start: got state=%0d on=%b spk=%b want 2 1 1", o_state, o_sound_on, o_speaker);
    end
    repeat (48) tick();
    n_checks++;
    if (o_state !== 3'd4 || o_sound_on !== 1'b0) begin
      n_fail++; $display("FAIL go_at_reset_end: got state=%0d on=%b want 4 0", o_state, o_sound_on);
    end
    i_gameOver = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      i_eat = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) i_gameOver = ~i_gameOver;
      tick();
      n_checks++;
      if ({o_state, o_sound_on, o_speaker} !== model_out()) begin
        n_fail++; $display("FAIL random[%0d]: got %b want %b", k, {o_state, o_sound_on, o_speaker}, model_out());
      end
    end
    i_eat = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_eat();
    test_retrigger();
    repeat (5) tick();
    test_go_preempt();
    test_go_pulse();
    test_go_at_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
